// File: rtl/lcd_text_streamer.sv
// lcd_text_streamer: writable ROWS x COLS character buffer streamed to a
// character LCD as repeated frames, each row preceded by a set-address command.
module lcd_text_streamer #(
    parameter int         ROWS      = 2,
    parameter int         COLS      = 16,
    parameter int         SETUP_CYC = 1,
    parameter int         EN_CYC    = 2,
    parameter int         HOLD_CYC  = 1,
    parameter int         RST_CYC   = 8,
    parameter int         GAP_CYC   = 4,
    parameter logic [7:0] FILL_CHAR = 8'h00,
    localparam int        NCHARS    = ROWS * COLS,
    localparam int        AW        = (NCHARS > 1) ? $clog2(NCHARS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          refresh_en,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          busy,
    output logic          frame_done,
    output logic          lcd_en,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic [7:0]    lcd_db,
    output logic          lcd_rst
);

    localparam int XFER_CYC = SETUP_CYC + EN_CYC + HOLD_CYC;
    localparam int CNT_MAX0 = (XFER_CYC - 1 > RST_CYC) ? XFER_CYC - 1 : RST_CYC;
    localparam int CNT_MAX  = (GAP_CYC > CNT_MAX0) ? GAP_CYC : CNT_MAX0;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW      = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [CW-1:0]  XFER_LAST = CW'(XFER_CYC - 1);
    localparam logic [CW-1:0]  EN_FIRST  = CW'(SETUP_CYC);
    localparam logic [CW-1:0]  EN_END    = CW'(SETUP_CYC + EN_CYC);
    localparam logic [CW-1:0]  RST_LAST  = CW'(RST_CYC);
    localparam logic [CW-1:0]  GAP_LAST  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CLW-1:0] COL_LAST  = CLW'(COLS - 1);

    typedef enum logic [2:0] {
        RST_WAIT,
        IDLE,
        CMD,
        DATA,
        GAP
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [RW-1:0]  row, row_nx;
    logic [CLW-1:0] col, col_nx;
    logic           busy_nx, done_nx, en_nx, rs_nx, lcd_rst_nx, load_char;
    logic [7:0]     db_nx;
    logic [7:0]     text_mem [NCHARS];

    // Set-DDRAM-address command for the start of a row
    function automatic logic [7:0] row_cmd(input logic [RW-1:0] r);
        logic [1:0] r2;
        logic [7:0] cmd;
        r2 = 2'(r);
        case (r2)
            2'd0:    cmd = 8'h80;
            2'd1:    cmd = 8'hC0;
            2'd2:    cmd = 8'h94;
            default: cmd = 8'hD4;
        endcase
        return cmd;
    endfunction

    assign lcd_rw = 1'b0;

    // Text buffer: reset to fill glyph, host writes accepted in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCHARS; i++) begin
                text_mem[AW'(i)] <= FILL_CHAR;
            end
        end else if (wr_en && (32'(wr_addr) < 32'(NCHARS))) begin
            text_mem[wr_addr] <= wr_data;
        end
    end

    // State, counters and registered pin values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RST_WAIT;
            cnt        <= '0;
            row        <= '0;
            col        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            lcd_en     <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_db     <= '0;
            lcd_rst    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            row        <= row_nx;
            col        <= col_nx;
            busy       <= busy_nx;
            frame_done <= done_nx;
            lcd_en     <= en_nx;
            lcd_rs     <= rs_nx;
            lcd_db     <= db_nx;
            lcd_rst    <= lcd_rst_nx;
        end
    end

    // Next state; pin values are derived from the next state so every pin is a flop.
    // The buffer read happens on the edge that opens a transfer's setup phase,
    // so a write committing on that same edge is seen only in the next frame.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        row_nx     = row;
        col_nx     = col;
        busy_nx    = busy;
        rs_nx      = lcd_rs;
        db_nx      = lcd_db;
        lcd_rst_nx = lcd_rst;
        load_char  = 1'b0;
        case (state)
            RST_WAIT: begin
                if (cnt == RST_LAST) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    lcd_rst_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            IDLE: begin
                busy_nx = 1'b0;
                if (refresh_en) begin
                    state_nx = CMD;
                    cnt_nx   = '0;
                    row_nx   = '0;
                    col_nx   = '0;
                    busy_nx  = 1'b1;
                    rs_nx    = 1'b0;
                    db_nx    = row_cmd('0);
                end
            end
            CMD, DATA: begin
                if (cnt != XFER_LAST) begin
                    cnt_nx = cnt + 1'b1;
                end else begin
                    cnt_nx = '0;
                    if (state == CMD) begin
                        state_nx  = DATA;
                        col_nx    = '0;
                        rs_nx     = 1'b1;
                        load_char = 1'b1;
                    end else if (col != COL_LAST) begin
                        col_nx    = col + 1'b1;
                        load_char = 1'b1;
                    end else if (row != ROW_LAST) begin
                        state_nx = CMD;
                        row_nx   = row + 1'b1;
                        rs_nx    = 1'b0;
                        db_nx    = row_cmd(row + 1'b1);
                    end else begin
                        state_nx = (GAP_CYC > 0) ? GAP : IDLE;
                        busy_nx  = 1'b0;
                        rs_nx    = 1'b0;
                        db_nx    = '0;
                    end
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = RST_WAIT;
        endcase
        if (load_char) begin
            db_nx = text_mem[AW'(32'(row_nx) * COLS + 32'(col_nx))];
        end
        en_nx   = ((state_nx == CMD) || (state_nx == DATA)) &&
                  (cnt_nx >= EN_FIRST) && (cnt_nx < EN_END);
        done_nx = (state_nx == DATA) && (row_nx == ROW_LAST) &&
                  (col_nx == COL_LAST) && (cnt_nx == XFER_LAST);
    end

endmodule
